i2c_req_sequencer: RTL
======================

Name: i2c_req_sequencer

Overview:
- Two-requester arbiter and transaction sequencer in front of the I2C master peripheral's 5-bit register bus.
- Accepts whole I2C transactions (7-bit target, R/W, byte count, write data), grants round-robin, and programs the master's ADR/NBY/TDR/CFG registers in order.
- Polls CFG for completion, drains the bus, reads RDR on reads, clears CFG, and returns one response to the winning requester.
- Lets the CPU path and a hardware requester (sensor poller/DMA) share one I2C master.

Parameters:
TIMEOUT_CYCLES, 65535, max POLL cycles before completion bit; expiry sets error
DRAIN_CYCLES, 4096, clk_i cycles waited after completion bit before RDR read/CFG clear (covers remaining bytes + STOP)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
r0_valid_i  in  1  requester 0 transaction valid
r0_ready_o  out  1  requester 0 accepted (1-cycle)
r0_rw_i  in  1  1=read, 0=write
r0_addr_i  in  7  I2C target address
r0_nby_i  in  2  byte count, 1..3 literal, 0 = 4 bytes
r0_wdata_i  in  32  write bytes, byte0 = [7:0]
r0_resp_valid_o  out  1  response strobe (1-cycle)
r0_resp_rdata_o  out  32  read data (0 on write)
r0_resp_err_o  out  1  timeout flag
r1_*  same set of 9 ports, same widths, for requester 1
m_write_o  out  1  master bus write strobe
m_be_o  out  4  master byte enables
m_addr_o  out  5  master byte address
m_wdata_o  out  32  master write data
m_rdata_i  in  32  master read data, combinational on m_addr_o/m_be_o

Behaviour:
- Master register map (byte addr): 0x00 NBY[1:0]; 0x04 ADR[6:0]; 0x08 RDR[31:0]; 0x0C TDR[31:0]; 0x10 CFG[3:0].
  - Write start: CFG=0x1. Write done: CFG bit1.
  - Read start: CFG=0x4. Read done: CFG bit3.
  - Master writes take effect at the next clk_i edge.
- Reset, and whenever not driven:
  - All outputs 0.
  - State IDLE; last_grant=1, so requester 0 wins first.
  - Reset mid-transaction aborts immediately: no response, no CFG clear issued.
- States and bus drive per cycle (m_* are 0 unless listed):
  - IDLE:
    - Any valid: assert winner's ready_o combinationally this cycle; latch rw/addr/nby/wdata and grant id at the edge; go WR_ADR.
    - Both valid: winner = requester != last_grant. Only one valid: that one wins.
    - last_grant updates on accept.
  - WR_ADR: write=1, addr=0x04, be=0001, wdata[6:0]=addr. Go WR_NBY.
  - WR_NBY: write=1, addr=0x00, be=0001, wdata[1:0]=nby, rest 0. Go WR_TDR on write, WR_CFG on read.
  - WR_TDR: write=1, addr=0x0C, be=1111, wdata=latched wdata. Go WR_CFG.
  - WR_CFG: write=1, addr=0x10, be=0001, wdata=0x1 (write) or 0x4 (read). Clear timeout counter. Go POLL.
  - POLL: write=0, addr=0x10, be=0001. Sample m_rdata_i[1] (write) or [3] (read).
    - Bit set: go DRAIN.
    - Else counter+1; counter reaching TIMEOUT_CYCLES sets err and goes CLR_CFG.
  - DRAIN: count DRAIN_CYCLES cycles, then go RD_RDR on read, CLR_CFG on write. DRAIN_CYCLES=0 means exactly 1 cycle.
  - RD_RDR: write=0, addr=0x08, be=1111. Capture m_rdata_i into rdata. Go CLR_CFG.
  - CLR_CFG: write=1, addr=0x10, be=0001, wdata=0. Go RESP.
  - RESP:
    - Pulse resp_valid_o of the granted requester for 1 cycle, with rdata (0 on write or error) and err.
    - Other requester's resp outputs stay 0. Go IDLE.
- A new accept is possible the cycle after RESP. Requests are never accepted outside IDLE.
- Write latency, accept to resp_valid, with completion at the first POLL and DRAIN_CYCLES=D: 7+D cycles.
  - Read: 7+D cycles (TDR skipped, RDR added).
- Counters are 16-bit and saturate; no wrap.
- r*_valid_i deasserted before accept: no effect. Fields are captured only at accept.

Test Plan:
- r0 write, addr=0x50, nby=2, wdata=0xA5C3, master model sets CFG bit1 at 3rd POLL, DRAIN=2.
  -> Bus sequence: ADR 0x50, NBY 2, TDR 0x0000A5C3, CFG 0x1, 3 POLLs, 2 drain, CFG 0x0.
  -> r0_resp_valid_o pulses once, err=0, rdata=0.
- r1 read, addr=0x1D, nby=0, master model sets bit3 at 1st POLL, RDR=0xDEADBEEF.
  -> No TDR write; CFG 0x4.
  -> r1_resp_rdata_o=0xDEADBEEF, err=0, latency 7+D.
- r0 and r1 both valid continuously, after reset.
  -> Grants alternate r0, r1, r0, r1; each ready_o is a single 1-cycle pulse per transaction.
- Completion bit never set, TIMEOUT_CYCLES=8.
  -> 8 POLL cycles, then CFG 0x0 write, then resp with err=1, rdata=0.
- rst_i asserted during DRAIN.
  -> Next cycle all m_* and resp outputs 0, state IDLE; next simultaneous request grants r0.
- r1 valid pulses for 1 cycle while r0 transaction in progress.
  -> r1 not accepted, no r1 response; r0 completes normally.

Source files
------------

// File: rtl/i2c_req_sequencer.sv
// Two-requester round-robin arbiter that sequences whole I2C transactions onto
// the I2C master's register bus: program, poll, drain, read back, clear, respond.
module i2c_req_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned DRAIN_CYCLES   = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        r0_valid_i,
  output logic        r0_ready_o,
  input  logic        r0_rw_i,
  input  logic [6:0]  r0_addr_i,
  input  logic [1:0]  r0_nby_i,
  input  logic [31:0] r0_wdata_i,
  output logic        r0_resp_valid_o,
  output logic [31:0] r0_resp_rdata_o,
  output logic        r0_resp_err_o,
  input  logic        r1_valid_i,
  output logic        r1_ready_o,
  input  logic        r1_rw_i,
  input  logic [6:0]  r1_addr_i,
  input  logic [1:0]  r1_nby_i,
  input  logic [31:0] r1_wdata_i,
  output logic        r1_resp_valid_o,
  output logic [31:0] r1_resp_rdata_o,
  output logic        r1_resp_err_o,
  output logic        m_write_o,
  output logic [3:0]  m_be_o,
  output logic [4:0]  m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic [31:0] m_rdata_i
);

  typedef enum logic [3:0] {
    IDLE, WR_ADR, WR_NBY, WR_TDR, WR_CFG, POLL, DRAIN, RD_RDR, CLR_CFG, RESP
  } state_e;

  typedef struct packed {
    logic        write;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } bus_t;

  localparam logic [4:0] A_NBY = 5'h00;
  localparam logic [4:0] A_ADR = 5'h04;
  localparam logic [4:0] A_RDR = 5'h08;
  localparam logic [4:0] A_TDR = 5'h0C;
  localparam logic [4:0] A_CFG = 5'h10;

  function automatic bus_t bus_op(input logic wr, input logic [4:0] a,
                                  input logic [3:0] be, input logic [31:0] d);
    bus_t b;
    b.write = wr;
    b.be    = be;
    b.addr  = a;
    b.wdata = d;
    return b;
  endfunction

  state_e      state_q;
  logic        last_grant_q, gid_q, rw_q, err_q;
  logic [6:0]  addr_q;
  logic [1:0]  nby_q;
  logic [31:0] wdata_q, rdata_q;
  logic [15:0] cnt_q;
  bus_t        bus_q;
  logic        r0_resp_valid_q, r0_resp_err_q, r1_resp_valid_q, r1_resp_err_q;
  logic [31:0] r0_resp_rdata_q, r1_resp_rdata_q;

  logic        pick0, pick1, accept, sel_rw, done_bit, poll_expired, drain_done;
  logic [6:0]  sel_addr;
  logic [1:0]  sel_nby;
  logic [31:0] sel_wdata;
  logic [15:0] cnt_inc;

  // Contention goes to the requester that did not win last time.
  assign pick0  = r0_valid_i && (!r1_valid_i || last_grant_q);
  assign pick1  = r1_valid_i && !pick0;
  assign accept = !rst_i && (state_q == IDLE) && (r0_valid_i || r1_valid_i);

  assign r0_ready_o = accept && pick0;
  assign r1_ready_o = accept && pick1;

  assign sel_rw    = pick0 ? r0_rw_i    : r1_rw_i;
  assign sel_addr  = pick0 ? r0_addr_i  : r1_addr_i;
  assign sel_nby   = pick0 ? r0_nby_i   : r1_nby_i;
  assign sel_wdata = pick0 ? r0_wdata_i : r1_wdata_i;

  assign cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
  assign done_bit     = rw_q ? m_rdata_i[3] : m_rdata_i[1];
  assign poll_expired = (32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES;
  assign drain_done   = (32'(cnt_q) + 32'd1) >= DRAIN_CYCLES;

  // Bus outputs are registered: each transition loads the drive of the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      gid_q           <= 1'b0;
      rw_q            <= 1'b0;
      err_q           <= 1'b0;
      addr_q          <= '0;
      nby_q           <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      cnt_q           <= '0;
      bus_q           <= '0;
      r0_resp_valid_q <= 1'b0;
      r0_resp_err_q   <= 1'b0;
      r0_resp_rdata_q <= '0;
      r1_resp_valid_q <= 1'b0;
      r1_resp_err_q   <= 1'b0;
      r1_resp_rdata_q <= '0;
    end else begin
      bus_q           <= '0;
      r0_resp_valid_q <= 1'b0;
      r0_resp_err_q   <= 1'b0;
      r0_resp_rdata_q <= '0;
      r1_resp_valid_q <= 1'b0;
      r1_resp_err_q   <= 1'b0;
      r1_resp_rdata_q <= '0;
      case (state_q)
        IDLE: if (accept) begin
          gid_q        <= pick1;
          last_grant_q <= pick1;
          rw_q         <= sel_rw;
          addr_q       <= sel_addr;
          nby_q        <= sel_nby;
          wdata_q      <= sel_wdata;
          rdata_q      <= '0;
          err_q        <= 1'b0;
          bus_q        <= bus_op(1'b1, A_ADR, 4'b0001, {25'd0, sel_addr});
          state_q      <= WR_ADR;
        end
        WR_ADR: begin
          bus_q   <= bus_op(1'b1, A_NBY, 4'b0001, {30'd0, nby_q});
          state_q <= WR_NBY;
        end
        WR_NBY: begin
          if (rw_q) begin
            bus_q   <= bus_op(1'b1, A_CFG, 4'b0001, 32'h4);
            state_q <= WR_CFG;
          end else begin
            bus_q   <= bus_op(1'b1, A_TDR, 4'b1111, wdata_q);
            state_q <= WR_TDR;
          end
        end
        WR_TDR: begin
          bus_q   <= bus_op(1'b1, A_CFG, 4'b0001, 32'h1);
          state_q <= WR_CFG;
        end
        WR_CFG: begin
          cnt_q   <= '0;
          bus_q   <= bus_op(1'b0, A_CFG, 4'b0001, '0);
          state_q <= POLL;
        end
        POLL: begin
          if (done_bit) begin
            cnt_q   <= '0;
            state_q <= DRAIN;
          end else if (poll_expired) begin
            err_q   <= 1'b1;
            bus_q   <= bus_op(1'b1, A_CFG, 4'b0001, '0);
            state_q <= CLR_CFG;
          end else begin
            cnt_q   <= cnt_inc;
            bus_q   <= bus_op(1'b0, A_CFG, 4'b0001, '0);
          end
        end
        DRAIN: begin
          if (drain_done) begin
            if (rw_q) begin
              bus_q   <= bus_op(1'b0, A_RDR, 4'b1111, '0);
              state_q <= RD_RDR;
            end else begin
              bus_q   <= bus_op(1'b1, A_CFG, 4'b0001, '0);
              state_q <= CLR_CFG;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        RD_RDR: begin
          rdata_q <= m_rdata_i;
          bus_q   <= bus_op(1'b1, A_CFG, 4'b0001, '0);
          state_q <= CLR_CFG;
        end
        CLR_CFG: begin
          if (gid_q) begin
            r1_resp_valid_q <= 1'b1;
            r1_resp_err_q   <= err_q;
            r1_resp_rdata_q <= rdata_q;
          end else begin
            r0_resp_valid_q <= 1'b1;
            r0_resp_err_q   <= err_q;
            r0_resp_rdata_q <= rdata_q;
          end
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_write_o       = bus_q.write;
  assign m_be_o          = bus_q.be;
  assign m_addr_o        = bus_q.addr;
  assign m_wdata_o       = bus_q.wdata;
  assign r0_resp_valid_o = r0_resp_valid_q;
  assign r0_resp_rdata_o = r0_resp_rdata_q;
  assign r0_resp_err_o   = r0_resp_err_q;
  assign r1_resp_valid_o = r1_resp_valid_q;
  assign r1_resp_rdata_o = r1_resp_rdata_q;
  assign r1_resp_err_o   = r1_resp_err_q;

endmodule
